// File: rtl/ping_sequencer_pkg.sv
// ping_sequencer_pkg: shared widths, h-bridge command codes, FSM states and config record for the ping sequencer.
package ping_sequencer_pkg;
  localparam int CNT_W = 16;
  localparam int SETTLE_CYC = 48;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {HB_OFF = 2'd0, HB_OSCL = 2'd1, HB_BRAKE = 2'd2} hb_t;
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_BURST, S_BRAKE, S_BLANK, S_LISTEN, S_DONE, S_WAIT} ping_state_t;
  typedef struct packed {
    cnt_t burst;
    cnt_t brake;
    cnt_t blank;
    cnt_t listen;
    cnt_t period;
  } ping_cfg_t;
endpackage

// File: rtl/ping_sequencer_if.sv
// ping_sequencer_if: control/config inputs and status outputs of one ping sequencer.
interface ping_sequencer_if;
  import ping_sequencer_pkg::*;
  logic start, abort, repeat_en;
  cnt_t burst_len, brake_len, blank_len, listen_len, period_len;
  hb_t hstate;
  logic txrx, rx_window, busy, ping_done, cfg_err;
  cnt_t ping_count;
  modport master (
    output start, abort, repeat_en, burst_len, brake_len, blank_len, listen_len, period_len,
    input hstate, txrx, rx_window, busy, ping_done, cfg_err, ping_count
  );
  modport slave (
    input start, abort, repeat_en, burst_len, brake_len, blank_len, listen_len, period_len,
    output hstate, txrx, rx_window, busy, ping_done, cfg_err, ping_count
  );
endinterface

// File: rtl/ping_sequencer_cfg_shadow.sv
// ping_cfg_shadow: holds the length/period fields captured at each SETTLE entry.
module ping_cfg_shadow
  import ping_sequencer_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load_i,
  input  ping_cfg_t cfg_i,
  output ping_cfg_t cfg_o
);
  ping_cfg_t cfg_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cfg_q <= '0;
    else if (load_i) cfg_q <= cfg_i;
  assign cfg_o = cfg_q;
endmodule

// File: rtl/ping_sequencer.sv
// ping_sequencer: sequences T/R settle, H-bridge burst, brake, blanking and listen window for one DVL ping.
module ping_sequencer
  import ping_sequencer_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  ping_sequencer_if.slave bus
);
  ping_state_t state_q, state_d, post_burst, post_brake;
  cnt_t cnt_q, cnt_d, el_q, count_q, len;
  ping_cfg_t cfg_in, cfg;
  hb_t hstate_q;
  logic abrt_q, load, fin, txrx_q, rx_q, busy_q, done_q, err_q;
  assign cfg_in = '{burst: bus.burst_len, brake: bus.brake_len, blank: bus.blank_len,
                    listen: bus.listen_len, period: bus.period_len};
  ping_cfg_shadow u_shadow (.clk(clk), .rst_n(rst_n), .load_i(load), .cfg_i(cfg_in), .cfg_o(cfg));
  assign fin = cnt_q == '0;
  assign load = state_d == S_SETTLE && state_q != S_SETTLE;
  // zero-length BRAKE/BLANK/LISTEN are skipped by choosing the next non-empty state
  assign post_brake = cfg.blank != '0 ? S_BLANK : cfg.listen != '0 ? S_LISTEN : S_DONE;
  assign post_burst = cfg.brake != '0 ? S_BRAKE : post_brake;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = bus.start && !bus.abort && bus.burst_len != '0 ? S_SETTLE : S_IDLE;
      S_SETTLE: state_d = bus.abort ? S_IDLE : fin ? S_BURST : S_SETTLE;
      S_BURST:  state_d = bus.abort ? (cfg.brake != '0 ? S_BRAKE : S_IDLE) : fin ? post_burst : S_BURST;
      S_BRAKE:  state_d = bus.abort || (fin && abrt_q) ? S_IDLE : fin ? post_brake : S_BRAKE;
      S_BLANK:  state_d = bus.abort ? S_IDLE : fin ? (cfg.listen != '0 ? S_LISTEN : S_DONE) : S_BLANK;
      S_LISTEN: state_d = bus.abort ? S_IDLE : fin ? S_DONE : S_LISTEN;
      S_DONE:   state_d = bus.abort || !bus.repeat_en ? S_IDLE : S_WAIT;
      S_WAIT:   state_d = bus.abort || !bus.repeat_en ? S_IDLE : el_q >= cfg.period ? S_SETTLE : S_WAIT;
      default:  state_d = S_IDLE;
    endcase
  end
  always_comb begin
    len = state_d == S_SETTLE ? cnt_t'(SETTLE_CYC) :
          state_d == S_BURST  ? cfg.burst :
          state_d == S_BRAKE  ? cfg.brake :
          state_d == S_BLANK  ? cfg.blank :
          state_d == S_LISTEN ? cfg.listen : '0;
    cnt_d = state_d != state_q ? (len != '0 ? len - 1'b1 : '0) : fin ? '0 : cnt_q - 1'b1;
  end
  // outputs are registered from the next state so they align with state_q
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      el_q     <= '0;
      abrt_q   <= 1'b0;
      hstate_q <= HB_OFF;
      txrx_q   <= 1'b0;
      rx_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      el_q     <= load ? cnt_t'(1) : el_q + cnt_t'(el_q != '1);
      abrt_q   <= state_d == S_BRAKE && (abrt_q || (state_q == S_BURST && bus.abort));
      hstate_q <= state_d == S_BURST ? HB_OSCL : state_d == S_BRAKE ? HB_BRAKE : HB_OFF;
      txrx_q   <= state_d inside {S_SETTLE, S_BURST, S_BRAKE};
      rx_q     <= state_d == S_LISTEN;
      busy_q   <= state_d != S_IDLE;
      done_q   <= state_d == S_DONE;
      err_q    <= state_q == S_IDLE && bus.start && !bus.abort && bus.burst_len == '0;
      count_q  <= count_q + cnt_t'(state_d == S_DONE);
    end
  assign bus.hstate     = hstate_q;
  assign bus.txrx       = txrx_q;
  assign bus.rx_window  = rx_q;
  assign bus.busy       = busy_q;
  assign bus.ping_done  = done_q;
  assign bus.cfg_err    = err_q;
  assign bus.ping_count = count_q;
endmodule

// File: tb/tb_ping_sequencer.sv
// tb_ping_sequencer: directed pings with a per-ping expectation queue checked at each ping_done.
module tb_ping_sequencer;
  import ping_sequencer_pkg::*;
  typedef struct {int tx; int osc; int brk; int rx; logic [15:0] cnt;} exp_t;
  logic clk = 1'b0, rst_n;
  ping_sequencer_if bus ();
  ping_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  exp_t sb[$];
  int rises[$];
  int n_cmp = 0, n_err = 0, cyc_g = 0;
  int m_tx, m_osc, m_brk, m_rx, m_done, m_viol;
  logic first_busy, p_tx, p_rx;
  logic [15:0] exp_cnt = '0;
  hb_t p_hs;
  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic set_cfg(input int b, input int br, input int bl, input int li, input int per);
    bus.burst_len = 16'(b); bus.brake_len = 16'(br); bus.blank_len = 16'(bl);
    bus.listen_len = 16'(li); bus.period_len = 16'(per);
  endtask
  task automatic push(input int b, input int br, input int bl, input int li);
    exp_t e;
    exp_cnt++;
    e.tx = SETTLE_CYC + b + br; e.osc = b; e.brk = br; e.rx = li; e.cnt = exp_cnt;
    sb.push_back(e);
  endtask
  task automatic watch(input int n_done, input int abort_osc, input int limit);
    int seen = 0;
    bit ok = 0;
    exp_t e;
    m_tx = 0; m_osc = 0; m_brk = 0; m_rx = 0; m_done = 0; m_viol = 0;
    p_tx = bus.txrx; p_rx = bus.rx_window; p_hs = bus.hstate;
    for (int c = 1; c <= limit && !ok; c++) begin
      @(negedge clk);
      cyc_g++;
      if (c == 1) first_busy = bus.busy;
      bus.start = 1'b0; bus.abort = 1'b0;
      if (bus.txrx && !p_tx) rises.push_back(cyc_g);
      if (p_hs == HB_OSCL && bus.hstate == HB_OFF) m_viol++;
      m_tx += int'(bus.txrx); m_rx += int'(bus.rx_window);
      m_osc += int'(bus.hstate == HB_OSCL); m_brk += int'(bus.hstate == HB_BRAKE);
      if (bus.ping_done) begin
        m_done++; seen++;
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("tx_cycles", m_tx, e.tx);
          chk("oscl_cycles", m_osc, e.osc);
          chk("brake_cycles", m_brk, e.brk);
          chk("rx_cycles", m_rx, e.rx);
          chk("ping_count", bus.ping_count, e.cnt);
          chk("done_after_listen", p_rx, e.rx != 0);
          m_tx = 0; m_osc = 0; m_brk = 0; m_rx = 0;
        end
      end
      if (abort_osc != 0 && m_osc == abort_osc && bus.hstate == HB_OSCL) bus.abort = 1'b1;
      p_tx = bus.txrx; p_rx = bus.rx_window; p_hs = bus.hstate;
      ok = (n_done != 0 && seen == n_done) || !bus.busy;
    end
    if (!ok) chk("watch_timeout", 0, 1);
  endtask
  initial begin
    rst_n = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.repeat_en = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_hstate", bus.hstate, HB_OFF);
    chk("rst_txrx", bus.txrx, 0);
    chk("rst_rx_window", bus.rx_window, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ping_done", bus.ping_done, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    chk("rst_count", bus.ping_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // nominal single ping
    set_cfg(100, 10, 20, 50, 0); push(100, 10, 20, 50);
    bus.start = 1'b1;
    watch(1, 0, 400);
    chk("t1_first_busy", first_busy, 1);
    chk("t1_no_oscl_to_off", m_viol, 0);
    @(negedge clk);
    chk("t1_idle_after", bus.busy, 0);
    // zero burst is rejected
    set_cfg(0, 10, 20, 50, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t2_cfg_err", bus.cfg_err, 1);
    chk("t2_busy", bus.busy, 0);
    chk("t2_hstate", bus.hstate, HB_OFF);
    @(negedge clk);
    chk("t2_cfg_err_pulse", bus.cfg_err, 0);
    // abort beats start in the same idle cycle
    set_cfg(10, 10, 20, 50, 0);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("abort_start_busy", bus.busy, 0);
    chk("abort_start_err", bus.cfg_err, 0);
    // periodic, period longer than the ping
    set_cfg(100, 10, 20, 50, 300); bus.repeat_en = 1'b1;
    push(100, 10, 20, 50); push(100, 10, 20, 50);
    rises.delete();
    bus.start = 1'b1;
    watch(2, 0, 800);
    chk("t3a_rises", rises.size(), 2);
    if (rises.size() == 2) chk("t3a_period", rises[1] - rises[0], 300);
    @(negedge clk);
    chk("t3a_wait_busy", bus.busy, 1);
    chk("t3a_wait_txrx", bus.txrx, 0);
    bus.repeat_en = 1'b0;
    @(negedge clk);
    chk("t3a_wait_exit", bus.busy, 0);
    // periodic, period shorter than the ping: WAIT is a single clock
    set_cfg(100, 10, 20, 50, 100); bus.repeat_en = 1'b1;
    push(100, 10, 20, 50); push(100, 10, 20, 50);
    rises.delete();
    bus.start = 1'b1;
    watch(2, 0, 800);
    chk("t3b_rises", rises.size(), 2);
    if (rises.size() == 2) chk("t3b_period", rises[1] - rises[0], 230);
    bus.repeat_en = 1'b0;
    @(negedge clk);
    chk("t3b_done_exit", bus.busy, 0);
    // abort during burst
    set_cfg(100, 10, 20, 50, 0);
    bus.start = 1'b1;
    watch(0, 40, 400);
    chk("t4_oscl", m_osc, 40);
    chk("t4_brake", m_brk, 10);
    chk("t4_rx", m_rx, 0);
    chk("t4_done", m_done, 0);
    chk("t4_no_oscl_to_off", m_viol, 0);
    chk("t4_count", bus.ping_count, exp_cnt);
    // zero-length brake/blank/listen
    set_cfg(30, 0, 0, 0, 0); push(30, 0, 0, 0);
    bus.start = 1'b1;
    watch(1, 0, 200);
    chk("t5_oscl_to_off", m_viol, 1);
    @(negedge clk);
    chk("t5_idle_after", bus.busy, 0);
    // asynchronous reset mid-burst
    set_cfg(100, 10, 20, 50, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (58) @(negedge clk);
    chk("t6_in_burst", bus.hstate, HB_OSCL);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_hstate", bus.hstate, HB_OFF);
    chk("t6_async_txrx", bus.txrx, 0);
    chk("t6_async_busy", bus.busy, 0);
    chk("t6_async_count", bus.ping_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    chk("t6_preload", bus.ping_count, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    set_cfg(5, 2, 2, 2, 0); push(5, 2, 2, 2);
    bus.start = 1'b1;
    watch(1, 0, 200);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
